// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register indexes, STATUS bit positions and the transmit FSM states.
package uart_tx_mmio_pkg;

    // Register indexes within the 16-byte window (addr[3:2])
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    // STATUS register bit positions
    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_FULL  = 1;
    localparam int unsigned STAT_EMPTY = 2;
    localparam int unsigned STAT_OVF   = 3;

    // Transmit FSM states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Assemble the STATUS read word; bits 31:4 read as zero
    function automatic logic [31:0] pack_status(
        input logic busy,
        input logic full,
        input logic empty,
        input logic ovf
    );
        logic [31:0] word;
        word             = '0;
        word[STAT_BUSY]  = busy;
        word[STAT_FULL]  = full;
        word[STAT_EMPTY] = empty;
        word[STAT_OVF]   = ovf;
        return word;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// DEPTH must be a power of two (pointers wrap naturally).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Storage write; the array itself is intentionally not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
// TXDATA pushes bytes into a small FIFO; STATUS reports busy/full/empty and a
// sticky overflow flag. The serial line is driven from a flop one cycle behind
// the FSM state, so the start bit appears on the edge after the FIFO pop.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        uart_tx_o
);

    localparam int unsigned CYC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_DIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'd7;
    localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic       sel;
    logic [1:0] reg_idx;
    logic       wr_sel;
    logic       rd_sel;
    logic       push_req;
    logic       ovf_clr;
    logic       ovf_set;

    // FIFO interface
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Transmit datapath
    tx_state_t        state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             line_d;
    logic             tx_q;
    logic             ovf_q;
    logic             busy;

    // Bits of the bus that carry no meaning for this block
    logic unused_bits;
    assign unused_bits = ^{data_i[31:8], addr_i[1:0], fifo_count};

    assign sel      = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_idx  = addr_i[3:2];
    assign wr_sel   = wr_en_i && sel;
    assign rd_sel   = rd_en_i && sel;
    assign push_req = wr_sel && (reg_idx == REG_TXDATA);
    assign ovf_clr  = wr_sel && (reg_idx == REG_STATUS) && data_i[STAT_OVF];

    // The FSM drains the FIFO only from IDLE, one byte per frame
    assign fifo_pop = (state_q == TX_IDLE) && !fifo_empty;
    // Dropped byte: FIFO full and no pop to make room this cycle
    assign ovf_set  = push_req && fifo_full && !fifo_pop;
    assign busy     = (state_q != TX_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata (data_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register read mux; combinational from pre-edge state
    always_comb begin
        data_o = '0;
        if (rd_sel && (reg_idx == REG_STATUS)) begin
            data_o = pack_status(busy, fifo_full, fifo_empty, ovf_q);
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    // FSM and datapath registers, including the registered serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= line_d;
        end
    end

    // Next-state, counter reloads and the line level for the current state
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        line_d  = 1'b1;
        case (state_q)
            TX_IDLE: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    shreg_d = fifo_rdata;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                line_d = 1'b0;
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            TX_DATA: begin
                line_d = shreg_q[0];
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            TX_STOP: begin
                line_d = 1'b1;
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with a line-decoding scoreboard.
module tb_uart_tx_mmio;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] BASE    = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        uart_tx_o;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (rd_en_i),
        .wr_en_i   (wr_en_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .uart_tx_o (uart_tx_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line monitor: samples at negedge, bit centres 4*(i+1)+2 samples after the first low
    int          mon_cnt = 0;
    logic        mon_busy = 1'b0;
    logic [7:0]  rx = '0;
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
            mon_cnt  = 0;
        end else if (!mon_busy) begin
            if (uart_tx_o === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) begin
                check("start_bit", {31'd0, uart_tx_o}, 32'd0);
            end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0) begin
                rx[(mon_cnt - 6) / 4] = uart_tx_o;
            end else if (mon_cnt == 38) begin
                check("stop_bit", {31'd0, uart_tx_o}, 32'd1);
                mon_exp = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
                check("rx_byte", {24'd0, rx}, mon_exp);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr_en_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk);
        wr_en_i = 1'b0; addr_i = '0; data_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd_en_i = 1'b1; addr_i = a;
        #1 d = data_o;
        @(negedge clk);
        rd_en_i = 1'b0; addr_i = '0;
    endtask

    task automatic bus_rw(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        rd_en_i = 1'b1; wr_en_i = 1'b1; addr_i = a; data_i = wd;
        #1 rd = data_o;
        @(negedge clk);
        rd_en_i = 1'b0; wr_en_i = 1'b0; addr_i = '0; data_i = '0;
    endtask

    task automatic wait_status(input logic [31:0] exp, input int max_cyc, input string tag);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < max_cyc; i++) begin
            bus_read(BASE + 32'h4, s);
            if (s === exp) break;
        end
        check(tag, s, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic        found;
        logic        saw_low;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_line", {31'd0, uart_tx_o}, 32'd1);
        check("reset_data_o", data_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(BASE + 32'h4, s);
        check("reset_status", s, 32'h4);
        bus_read(BASE, s);
        check("txdata_reads_zero", s, 32'h0);

        // Single frame 0x55 with start-bit latency
        sb.push_back(8'h55);
        bus_write(BASE, 32'h55);
        check("line_before_pop", {31'd0, uart_tx_o}, 32'd1);
        @(negedge clk);
        check("line_after_pop", {31'd0, uart_tx_o}, 32'd1);
        @(negedge clk);
        check("line_start_w+2", {31'd0, uart_tx_o}, 32'd0);
        bus_read(BASE + 32'h4, s);
        check("busy_in_frame", s, 32'h5);
        wait_status(32'h4, 80, "frame1_idle");
        check("frame1_consumed", 32'(sb.size()), 32'd0);

        // Burst of five fills the FIFO, sixth overflows
        for (int b = 1; b <= 5; b++) begin
            sb.push_back(8'(b));
            bus_write(BASE, 32'(b));
        end
        bus_read(BASE + 32'h4, s);
        check("burst_full_no_ovf", s, 32'h3);
        bus_write(BASE, 32'h06);
        bus_rw(BASE + 32'h4, 32'h8, s);
        check("ovf_preedge_read", s, 32'hB);
        wait_status(32'h4, 5 * 41 + 40, "drain_ovf_cleared");
        check("burst_consumed", 32'(sb.size()), 32'd0);

        // Write lands on the IDLE pop edge while the FIFO is full
        for (int b = 8'h11; b <= 8'h15; b++) begin
            sb.push_back(8'(b));
            bus_write(BASE, 32'(b));
        end
        repeat (37) @(negedge clk);
        sb.push_back(8'h16);
        bus_write(BASE, 32'h16);
        bus_read(BASE + 32'h4, s);
        check("full_pop_write", s, 32'h3);
        wait_status(32'h4, 6 * 41 + 40, "drain2_idle");
        check("full_pop_consumed", 32'(sb.size()), 32'd0);

        // Unselected and reserved addresses
        bus_write(BASE + 32'h10, 32'hAA);
        bus_write(BASE + 32'h8, 32'h5A);
        bus_read(BASE + 32'h10, s);
        check("unsel_read_zero", s, 32'h0);
        bus_read(BASE + 32'h8, s);
        check("idx2_read_zero", s, 32'h0);
        addr_i = BASE + 32'h4;
        #1 check("no_rd_en_zero", data_o, 32'h0);
        addr_i = '0;
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1) saw_low = 1'b1;
        end
        check("unsel_no_tx", {31'd0, saw_low}, 32'd0);
        bus_read(BASE + 32'h4, s);
        check("unsel_status", s, 32'h4);

        // Reset during data bit 3 of 0xA5
        sb.push_back(8'hA5);
        bus_write(BASE, 32'hA5);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mon_busy && mon_cnt == 18) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_bit3", {31'd0, found}, 32'd1);
        check("bit3_low", {31'd0, uart_tx_o}, 32'd0);
        rst_n = 1'b0;
        #1 check("reset_async_high", {31'd0, uart_tx_o}, 32'd1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        bus_read(BASE + 32'h4, s);
        check("post_reset_status", s, 32'h4);
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1) saw_low = 1'b1;
        end
        check("post_reset_idle", {31'd0, saw_low}, 32'd0);

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00001000: base of the 16-byte register window.
REQ-002 Parameter CLK_DIV, default 16: clk cycles per UART bit, legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 4: TX FIFO entries, power of two, at least 2.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rd_en_i  input  1  read strobe from the core bus.
REQ-007 wr_en_i  input  1  write strobe from the core bus.
REQ-008 addr_i  input  32  byte address from the core bus.
REQ-009 data_i  input  32  write data from the core bus.
REQ-010 data_o  output  32  read data to the core bus; combinational, valid in the same cycle as rd_en_i.
REQ-011 uart_tx_o  output  1  serial line; idles high.

Function
REQ-012 Selection: sel = (addr_i[31:4] == BASE_ADDR[31:4]); register index = addr_i[3:2]; addr_i[1:0] ignored.
REQ-013 Index 0 (TXDATA), write: push data_i[7:0] into the FIFO.
REQ-014 Index 0 (TXDATA), read: returns 0.
REQ-015 Index 1 (STATUS), read layout: bit0 busy (FSM not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits 31:4 zero.
REQ-016 STATUS write with data_i[3]=1 clears overflow; all other STATUS bits are read-only.
REQ-017 Indexes 2 and 3: read 0; writes ignored.
REQ-018 data_o = 0 whenever rd_en_i=0 or sel=0.
REQ-019 A write with sel=0 has no effect on any state.
REQ-020 A push is accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
REQ-021 A push that is not accepted drops the byte and sets overflow on the next edge; FIFO contents are unchanged.
REQ-022 If an overflow-set condition and a clear occur in the same cycle, set wins.
REQ-023 If rd_en_i and wr_en_i are both high in one cycle: perform the write, and return read data from pre-edge state.
REQ-024 FSM states: IDLE, START, DATA, STOP.
REQ-025 IDLE: uart_tx_o=1; if the FIFO is non-empty, pop the head into the shift register and go to START on the same edge.
REQ-026 START: uart_tx_o=0 for CLK_DIV cycles, then go to DATA.
REQ-027 DATA: shift out 8 bits LSB first, CLK_DIV cycles each, then go to STOP.
REQ-028 STOP: uart_tx_o=1 for CLK_DIV cycles, then go to IDLE.
REQ-029 Every frame spends at least one cycle in IDLE before the next pop, so frame-to-frame pitch is 10*CLK_DIV+1 cycles.
REQ-030 The start bit begins on the edge after the pop; the first TXDATA write to an empty FIFO makes uart_tx_o low 2 cycles after the write edge.
REQ-031 The bit-cycle counter and the bit-index counter are sized from CLK_DIV and 8; they wrap only via explicit reload, never by overflow.
REQ-032 uart_tx_o is driven from a flop (glitch-free).

Reset
REQ-033 rst_n low asynchronously forces: FSM to IDLE, uart_tx_o=1, FIFO empty (read/write pointers and count = 0), overflow=0, all counters 0.
REQ-034 Reset asserted mid-frame aborts the frame; the line goes high immediately and no partial byte resumes after release.
REQ-035 FIFO storage array is not reset; data_o depends only on reset-cleared state.

Structure
REQ-036 Shared package holds: register index constants (TXDATA=0, STATUS=1), STATUS bit positions, and the FSM state enum.
REQ-037 One sub-module, sync_fifo (parameterised width and depth, full/empty/count outputs), is instantiated for the TX queue.
REQ-038 The bus decode, status logic, and TX FSM live in uart_tx_mmio itself.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-039 Write 0x55 to BASE+0 -> uart_tx_o low 2 cycles later for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy reads 1 during the frame.
REQ-040 Five back-to-back TXDATA writes 0x01..0x05 while idle -> first byte pops at once, writes 2-5 fill the FIFO, and no overflow occurs. Sixth write 0x06 -> overflow=1 and 0x06 is never transmitted.
REQ-041 With overflow set, write 0x8 to BASE+4 -> STATUS reads 0x4 after the FIFO drains and the FSM returns to IDLE.
REQ-042 Write and read at BASE+0x10 and at BASE+8 -> no transmission, data_o=0, STATUS unchanged.
REQ-043 Assert rst_n low during DATA bit 3 -> uart_tx_o=1 in the same cycle; after release STATUS=0x4 and the line stays high.
REQ-044 FIFO full while IDLE pops and a write occurs in the same cycle -> write accepted, count stays 4, overflow stays 0.
